// File: rtl/stream_data_transformer.sv
// Packet-aware stream transformer (pass / byte-reverse / add / xor) with output FIFO.
// Define STREAM_XFORM_STATS_EN to build the output beat/packet counters.
module stream_data_transformer #(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BUS_WIDTH-1:0]     in_data,
    input  logic [DATA_BUS_WIDTH/8-1:0]   in_byte_en,
    input  logic                          in_valid,
    input  logic                          in_end,
    output logic                          in_ready,
    output logic [DATA_BUS_WIDTH-1:0]     out_data,
    output logic [DATA_BUS_WIDTH/8-1:0]   out_byte_en,
    output logic                          out_valid,
    output logic                          out_end,
    input  logic                          out_ready,
    input  logic [1:0]                    ctrl_sel,
    input  logic [DATA_BUS_WIDTH-1:0]     operand_val,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [STAT_WIDTH-1:0]         pkt_count,
    output logic [STAT_WIDTH-1:0]         beat_count
);

    localparam int BW = DATA_BUS_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] IN_PKT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DATA_BUS_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [BW-1:0]             mem_be   [FIFO_DEPTH];
    logic                      mem_end  [FIFO_DEPTH];

    logic                      push, pop;
    logic [1:0]                cur_mode;
    logic [DATA_BUS_WIDTH-1:0] xf_data;
    logic [BW-1:0]             xf_be;

    assign in_ready   = !reset && (cnt_q < DEPTH_C);
    assign out_valid  = (cnt_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign fill_level = cnt_q;

    // Gate the head so outputs read as zero whenever the buffer is empty
    assign out_data    = out_valid ? mem_data[rptr_q] : '0;
    assign out_byte_en = out_valid ? mem_be[rptr_q]   : '0;
    assign out_end     = out_valid ? mem_end[rptr_q]  : 1'b0;

    // First beat of a packet uses ctrl_sel directly; later beats use the latched mode
    assign cur_mode = (state_q == IDLE) ? ctrl_sel : mode_q;

    always_comb begin
        xf_data = in_data;
        xf_be   = in_byte_en;
        case (cur_mode)
            2'd1: begin
                for (int i = 0; i < BW; i++) begin
                    xf_data[8*i +: 8] = in_data[8*(BW-1-i) +: 8];
                    xf_be[i]          = in_byte_en[BW-1-i];
                end
            end
            2'd2:    xf_data = in_data + operand_val;
            2'd3:    xf_data = in_data ^ operand_val;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (push) begin
            if (state_q == IDLE) begin
                mode_d = ctrl_sel;
            end
            state_d = in_end ? IDLE : IN_PKT;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wptr_q] <= xf_data;
            mem_be[wptr_q]   <= xf_be;
            mem_end[wptr_q]  <= in_end;
        end
    end

`ifdef STREAM_XFORM_STATS_EN
    logic [STAT_WIDTH-1:0] beat_q, beat_d;
    logic [STAT_WIDTH-1:0] pkt_q, pkt_d;

    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            beat_d = beat_q + STAT_WIDTH'(1);
            if (out_end) begin
                pkt_d = pkt_q + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_q <= '0;
            pkt_q  <= '0;
        end else begin
            beat_q <= beat_d;
            pkt_q  <= pkt_d;
        end
    end

    assign beat_count = beat_q;
    assign pkt_count  = pkt_q;
`else
    assign beat_count = '0;
    assign pkt_count  = '0;
`endif

endmodule

// File: doc/stream_data_transformer.md
STREAM_DATA_TRANSFORMER -- requirements
Module: stream_data_transformer

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 32, data bus width in bits (multiple of 8, min 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in beats (power of 2, min 2).
REQ-003 SHALL have parameter STAT_WIDTH, default 32, width of statistics counters.
REQ-004 SHALL have ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous active-high reset.
- in_data  in  DATA_BUS_WIDTH  input beat data.
- in_byte_en  in  DATA_BUS_WIDTH/8  input byte enables.
- in_valid  in  1  input beat valid.
- in_end  in  1  last beat of packet.
- in_ready  out  1  block can accept a beat.
- out_data  out  DATA_BUS_WIDTH  transformed data.
- out_byte_en  out  DATA_BUS_WIDTH/8  output byte enables.
- out_valid  out  1  output beat valid.
- out_end  out  1  last beat of packet.
- out_ready  in  1  downstream accepts beat.
- ctrl_sel  in  2  mode: 0 pass, 1 byte reverse, 2 add, 3 xor.
- operand_val  in  DATA_BUS_WIDTH  add/xor operand.
- fill_level  out  clog2(FIFO_DEPTH)+1  beats held in buffer.
- pkt_count  out  STAT_WIDTH  completed output packets (stats build only).
- beat_count  out  STAT_WIDTH  output beats transferred (stats build only).

Function
REQ-005 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-006 in_ready SHALL equal (fill_level < FIFO_DEPTH), independent of in_valid and out_ready.
REQ-007 Transformed beat SHALL be written into the FIFO on the input transfer cycle; out_valid SHALL assert the following cycle when the FIFO was empty (latency 1).
REQ-008 out_data/out_byte_en/out_end SHALL come from the FIFO head register and SHALL stay stable while out_valid && !out_ready.
REQ-009 Packet state machine SHALL have states IDLE and IN_PKT; IDLE->IN_PKT on transfer with in_end=0; IN_PKT->IDLE on transfer with in_end=1; IDLE stays IDLE on single-beat packet (in_end=1).
REQ-010 Mode SHALL be sampled from ctrl_sel on the first beat of each packet (transfer in IDLE) and held in a mode register for all beats of that packet; ctrl_sel changes mid-packet SHALL be ignored.
REQ-011 Mode 0 SHALL pass data and byte_en unchanged.
REQ-012 Mode 1 SHALL reverse byte order of data (byte i <- byte N-1-i) and reverse byte_en bits identically.
REQ-013 Mode 2 SHALL output (in_data + operand_val) mod 2^DATA_BUS_WIDTH, carry discarded; byte_en unchanged.
REQ-014 Mode 3 SHALL output in_data XOR operand_val; byte_en unchanged.
REQ-015 operand_val SHALL be sampled per beat, not latched per packet.
REQ-016 Simultaneous push and pop SHALL leave fill_level unchanged; with FIFO full, no push occurs (in_ready=0) and a pop SHALL raise in_ready the next cycle.
REQ-017 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH without data loss or duplication.

Reset
REQ-018 On reset assertion, asynchronously: out_valid=0, out_end=0, out_byte_en=0, out_data=0, fill_level=0, pointers=0, state=IDLE, mode register=0, pkt_count=0, beat_count=0.
REQ-019 in_ready SHALL be 0 while reset is asserted and SHALL be 1 on the first clock after deassertion.
REQ-020 Reset mid-packet SHALL discard all buffered beats; the next accepted beat SHALL be treated as a packet start.

Configuration
REQ-021 Macro STREAM_XFORM_STATS_EN defined: beat_count SHALL increment per output transfer, pkt_count per output transfer with out_end=1, both wrapping at 2^STAT_WIDTH.
REQ-022 Macro STREAM_XFORM_STATS_EN undefined: pkt_count and beat_count SHALL be tied to 0 and no counter registers synthesised.

Verification
REQ-023 Mode 1, 32-bit, in_data=0x11223344, byte_en=0b0011, single beat -> out_data=0x44332211, out_byte_en=0b1100, out_end=1, one cycle later.
REQ-024 Mode 2, in_data=0xFFFFFFFF, operand_val=0x2 -> out_data=0x00000001.
REQ-025 3-beat packet starting ctrl_sel=3, operand 0xFF00FF00, ctrl_sel switched to 0 after beat 1 -> all 3 beats XORed.
REQ-026 out_ready=0, push 5 beats, FIFO_DEPTH=4 -> in_ready=0 after 4th, fill_level=4; release out_ready -> 4 beats in order, then 5th.
REQ-027 Reset asserted with 2 beats buffered mid-packet -> out_valid=0, fill_level=0 immediately; next beat sampled ctrl_sel as new packet mode.
REQ-028 STREAM_XFORM_STATS_EN defined, two packets of 3 and 1 beats drained -> beat_count=4, pkt_count=2; undefined -> both 0.
